// File: rtl/gdp_pkg.sv
// gdp_pkg
//   Shared definitions for the streaming diagonal-Gaussian log-probability
//   block: default fixed-point format, operand type, pipeline sideband
//   struct and the saturating truncation helper used by the accumulator and
//   the output clamp.
package gdp_pkg;

  localparam int W_DEF     = 16;  // operand / result width
  localparam int F_DEF     = 11;  // fractional bits (1.0 = 2^F)
  localparam int ACC_W_DEF = 40;  // accumulator width, >= 2*W+2

  typedef logic signed [W_DEF-1:0] num_t;

  // Per-stage sideband travelling alongside the data.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } ctl_t;

  // Clamp a signed value to the signed range of 'width' bits (width <= 64).
  // The caller detects clamping by comparing the result with the input.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/gdp_term.sv
// gdp_term
//   Three-stage, stall-able term pipeline:
//     S1: d    = x - mean                  (W+1 bits, exact)
//     S2: sq   = (d*d) >>> F               (2W+2 bits, floor)
//     S3: term = (sq * omega) >>> F        (sign-extended to ACC_W)
//   Valid/first/last flags and k travel alongside the data.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   en_i                advance the pipeline (low = hold every register)
//   ctl_i               valid/first/last of the incoming beat
//   x_i, mean_i,
//   omega_i, k_i        signed Q(W-F).F operands
//   ctl_o, k_o, term_o  S3 sideband, k and scaled squared-error term
module gdp_term
  import gdp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int F     = F_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  ctl_t                    ctl_i,
  input  logic signed [W-1:0]     x_i,
  input  logic signed [W-1:0]     mean_i,
  input  logic signed [W-1:0]     omega_i,
  input  logic signed [W-1:0]     k_i,
  output ctl_t                    ctl_o,
  output logic signed [W-1:0]     k_o,
  output logic signed [ACC_W-1:0] term_o
);

  localparam int D_W  = W + 1;
  localparam int SQ_W = 2 * W + 2;
  localparam int PR_W = SQ_W + W;

  ctl_t                    s1_ctl_q, s2_ctl_q, s3_ctl_q;
  logic signed [W-1:0]     s1_k_q, s2_k_q, s3_k_q;
  logic signed [W-1:0]     s1_omega_q, s2_omega_q;
  logic signed [D_W-1:0]   s1_d_q, s1_d_d;
  logic signed [SQ_W-1:0]  s2_sq_q, s2_sq_d;
  logic signed [ACC_W-1:0] s3_term_q, s3_term_d;
  logic signed [SQ_W-1:0]  sq_full;
  logic signed [PR_W-1:0]  prod;

  always_comb begin
    s1_d_d    = D_W'(x_i) - D_W'(mean_i);
    // |d| <= 2^W, so d*d fits in 2W+2 signed bits without loss.
    sq_full   = SQ_W'(s1_d_q) * SQ_W'(s1_d_q);
    s2_sq_d   = sq_full >>> F;
    prod      = PR_W'(s2_sq_q) * PR_W'(s2_omega_q);
    s3_term_d = ACC_W'(prod >>> F);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_ctl_q   <= '0;
      s2_ctl_q   <= '0;
      s3_ctl_q   <= '0;
      s1_k_q     <= '0;
      s2_k_q     <= '0;
      s3_k_q     <= '0;
      s1_omega_q <= '0;
      s2_omega_q <= '0;
      s1_d_q     <= '0;
      s2_sq_q    <= '0;
      s3_term_q  <= '0;
    end else if (en_i) begin
      s1_ctl_q   <= ctl_i;
      s1_k_q     <= k_i;
      s1_omega_q <= omega_i;
      s1_d_q     <= s1_d_d;
      s2_ctl_q   <= s1_ctl_q;
      s2_k_q     <= s1_k_q;
      s2_omega_q <= s1_omega_q;
      s2_sq_q    <= s2_sq_d;
      s3_ctl_q   <= s2_ctl_q;
      s3_k_q     <= s2_k_q;
      s3_term_q  <= s3_term_d;
    end
  end

  assign ctl_o  = s3_ctl_q;
  assign k_o    = s3_k_q;
  assign term_o = s3_term_q;

endmodule

// File: rtl/gdp_stream.sv
// gdp_stream
//   Streaming accumulator of ln p = k - 0.5 * sum omega_i*(x_i-mean_i)^2,
//   one dimension per beat, with valid/ready on both sides. Terms come from
//   gdp_term (S1-S3); this module adds the saturating accumulator (S4), the
//   clamped output register (S5) and the back-pressure logic.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   in_valid/in_ready        input handshake, one dimension per beat
//   in_first/in_last         vector delimiters (k sampled on the last beat)
//   x, mean, omega, k        signed Q(W-F).F operands
//   out_valid/out_ready      output handshake, result held until accepted
//   out_ln_p                 signed Q(W-F).F log-probability
//   out_sat                  result clamped or accumulator saturated
module gdp_stream
  import gdp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int F     = F_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] mean,
  input  logic signed [W-1:0] omega,
  input  logic signed [W-1:0] k,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_ln_p,
  output logic                out_sat
);

  localparam int SUM_W = ACC_W + 1;

  logic                    stall;
  ctl_t                    in_ctl;
  ctl_t                    term_ctl;
  logic signed [W-1:0]     term_k;
  logic signed [ACC_W-1:0] term;

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic                    ovf_q, ovf_d;
  logic                    s4_valid_q, s4_last_q;
  logic signed [W-1:0]     s4_k_q;
  logic                    out_valid_q, out_valid_d;
  logic signed [W-1:0]     out_ln_p_q, out_ln_p_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [SUM_W-1:0] sum;
  logic signed [63:0]      sum_sat;
  logic signed [SUM_W-1:0] r;
  logic signed [63:0]      r_sat;

  // A held result blocks the whole pipeline so nothing overtakes it.
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  assign in_ctl = '{valid: in_valid, first: in_first, last: in_last};

  gdp_term #(
    .W     (W),
    .F     (F),
    .ACC_W (ACC_W)
  ) u_term (
    .clk     (clk),
    .reset   (reset),
    .en_i    (!stall),
    .ctl_i   (in_ctl),
    .x_i     (x),
    .mean_i  (mean),
    .omega_i (omega),
    .k_i     (k),
    .ctl_o   (term_ctl),
    .k_o     (term_k),
    .term_o  (term)
  );

  // S4: a first beat restarts from zero (dropping any partial vector) and
  // clears the sticky overflow before its own saturation check.
  always_comb begin
    acc_base = term_ctl.first ? '0 : acc_q;
    sum      = SUM_W'(acc_base) + SUM_W'(term);
    sum_sat  = sat_trunc(64'(sum), ACC_W);
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (term_ctl.valid) begin
      acc_d = ACC_W'(sum_sat);
      ovf_d = (term_ctl.first ? 1'b0 : ovf_q) | (sum_sat != 64'(sum));
    end
  end

  // S5: only a last beat produces a result; otherwise an accepted result
  // simply retires.
  always_comb begin
    r           = SUM_W'(s4_k_q) - SUM_W'(acc_q >>> 1);
    r_sat       = sat_trunc(64'(r), W);
    out_valid_d = out_valid_q && !out_ready;
    out_ln_p_d  = out_ln_p_q;
    out_sat_d   = out_sat_q;
    if (s4_valid_q && s4_last_q) begin
      out_valid_d = 1'b1;
      out_ln_p_d  = W'(r_sat);
      out_sat_d   = (r_sat != 64'(r)) || ovf_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      s4_valid_q  <= 1'b0;
      s4_last_q   <= 1'b0;
      s4_k_q      <= '0;
      out_valid_q <= 1'b0;
      out_ln_p_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (!stall) begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      s4_valid_q  <= term_ctl.valid;
      s4_last_q   <= term_ctl.last;
      s4_k_q      <= term_k;
      out_valid_q <= out_valid_d;
      out_ln_p_q  <= out_ln_p_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ln_p  = out_ln_p_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_gdp_stream.sv
// tb_gdp_stream
//   Directed-vector bench for gdp_stream at W=16, F=11, ACC_W=40
//   (1.0 = 2048). Expected results are hand-computed constants.
module tb_gdp_stream;
  import gdp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, in_first, in_last;
  num_t x, mean, omega, k;
  logic out_valid, out_ready, out_sat;
  num_t out_ln_p;

  always #5 clk = ~clk;

  gdp_stream #(.W(16), .F(11), .ACC_W(40)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .x         (x),
    .mean      (mean),
    .omega     (omega),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ln_p  (out_ln_p),
    .out_sat   (out_sat)
  );

  typedef struct {
    int   ln;
    logic sat;
    int   cyc;
  } res_t;

  res_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted result (sampled mid-cycle, one line each).
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      res_t e;
      e.ln  = int'(out_ln_p);
      e.sat = out_sat;
      e.cyc = cyc;
      q.push_back(e);
      $display("result  ln_p=%0d sat=%0b cycle=%0d", e.ln, e.sat, e.cyc);
    end
  end

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic send_beat(input logic f, input logic l, input num_t xv,
                           input num_t mv, input num_t ov, input num_t kv);
    bit ok = 0;
    in_valid = 1'b1; in_first = f; in_last = l;
    x = xv; mean = mv; omega = ov; k = kv;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept: got in_ready=0 for 60 cycles expected 1");
    end
    @(posedge clk); #1;
    $display("beat    first=%0b last=%0b x=%0d mean=%0d omega=%0d k=%0d",
             f, l, xv, mv, ov, kv);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_ln_p !== 16'sd0) begin n_bad++; $display("FAIL rst_ln_p: got %0d expected 0", out_ln_p); end
    n_cmp++; if (out_sat !== 1'b0) begin n_bad++; $display("FAIL rst_sat: got %0b expected 0", out_sat); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    idle(3);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    q.delete();
    send_beat(1, 1, 2048, 0, 2048, 0);  // accepted on edge 1
    for (int i = 2; i <= 6; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== (i == 5)) begin
        n_bad++; $display("FAIL single_valid_edge%0d: got %0b expected %0b", i, out_valid, (i == 5));
      end
      if (i == 5) begin
        n_cmp++; if (out_ln_p !== -16'sd1024) begin n_bad++; $display("FAIL single_ln_p: got %0d expected -1024", out_ln_p); end
        n_cmp++; if (out_sat !== 1'b0) begin n_bad++; $display("FAIL single_sat: got %0b expected 0", out_sat); end
      end
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    int c0;
    q.delete();
    c0 = cyc;
    send_beat(1, 0, 100, 100, 1234, 0);
    send_beat(0, 0, -300, -300, 32767, 0);
    send_beat(0, 1, 5000, 5000, -5, 4096);
    send_beat(1, 0, 2048, 0, 2048, 0);
    send_beat(0, 0, 0, 0, 2048, 0);
    send_beat(0, 1, 4096, 2048, 2048, 0);
    idle(12);
    n_cmp++; if (q.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d expected 2", q.size()); end
    if (q.size() >= 2) begin
      n_cmp++; if (q[0].ln != 4096) begin n_bad++; $display("FAIL b2b_zero_err_ln_p: got %0d expected 4096", q[0].ln); end
      n_cmp++; if (q[0].sat !== 1'b0) begin n_bad++; $display("FAIL b2b_zero_err_sat: got %0b expected 0", q[0].sat); end
      n_cmp++; if (q[1].ln != -2048) begin n_bad++; $display("FAIL b2b_second_ln_p: got %0d expected -2048", q[1].ln); end
      n_cmp++; if (q[0].cyc - c0 != 7) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 7", q[0].cyc - c0); end
      n_cmp++; if (q[1].cyc - q[0].cyc != 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 3", q[1].cyc - q[0].cyc); end
    end
  endtask

  task automatic test_bubbles();
    int c0;
    q.delete();
    c0 = cyc;
    send_beat(1, 0, 2048, 0, 2048, 0);
    idle(2);
    send_beat(0, 0, 0, 0, 2048, 0);
    idle(2);
    send_beat(0, 1, 4096, 2048, 2048, 0);
    idle(12);
    n_cmp++; if (q.size() != 1) begin n_bad++; $display("FAIL bubble_count: got %0d expected 1", q.size()); end
    if (q.size() >= 1) begin
      n_cmp++; if (q[0].ln != -2048) begin n_bad++; $display("FAIL bubble_ln_p: got %0d expected -2048", q[0].ln); end
      n_cmp++; if (q[0].sat !== 1'b0) begin n_bad++; $display("FAIL bubble_sat: got %0b expected 0", q[0].sat); end
      n_cmp++; if (q[0].cyc - c0 != 11) begin n_bad++; $display("FAIL bubble_latency: got %0d expected 11", q[0].cyc - c0); end
    end
  endtask

  task automatic test_backpressure();
    q.delete();
    out_ready = 1'b0;
    fork
      begin
        send_beat(1, 1, 2048, 0, 2048, 0);      // -1024
        send_beat(1, 0, 2048, 0, 2048, 0);      // -2048
        send_beat(0, 0, 0, 0, 2048, 0);
        send_beat(0, 1, 4096, 2048, 2048, 0);
        send_beat(1, 1, 0, 0, 2048, 2048);      // 2048
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (out_valid) begin seen = 1; break; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_valid_rise: got 0 expected 1"); end
        for (int j = 0; j < 4; j++) begin
          if (j > 0) @(negedge clk);
          n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_c%0d: got %0b expected 0", j, in_ready); end
          n_cmp++; if (out_ln_p !== -16'sd1024) begin n_bad++; $display("FAIL bp_hold_c%0d: got %0d expected -1024", j, out_ln_p); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(15);
    n_cmp++; if (q.size() != 3) begin n_bad++; $display("FAIL bp_count: got %0d expected 3", q.size()); end
    if (q.size() >= 3) begin
      n_cmp++; if (q[0].ln != -1024) begin n_bad++; $display("FAIL bp_res0: got %0d expected -1024", q[0].ln); end
      n_cmp++; if (q[1].ln != -2048) begin n_bad++; $display("FAIL bp_res1: got %0d expected -2048", q[1].ln); end
      n_cmp++; if (q[2].ln != 2048) begin n_bad++; $display("FAIL bp_res2: got %0d expected 2048", q[2].ln); end
    end
  endtask

  task automatic test_saturation();
    q.delete();
    send_beat(1, 1, 32767, -32768, 32767, -32768);
    send_beat(1, 1, 2048, 0, 2048, 0);
    idle(12);
    n_cmp++; if (q.size() != 2) begin n_bad++; $display("FAIL sat_count: got %0d expected 2", q.size()); end
    if (q.size() >= 2) begin
      n_cmp++; if (q[0].ln != -32768) begin n_bad++; $display("FAIL sat_ln_p: got %0d expected -32768", q[0].ln); end
      n_cmp++; if (q[0].sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got %0b expected 1", q[0].sat); end
      n_cmp++; if (q[1].ln != -1024) begin n_bad++; $display("FAIL sat_next_ln_p: got %0d expected -1024", q[1].ln); end
      n_cmp++; if (q[1].sat !== 1'b0) begin n_bad++; $display("FAIL sat_next_flag: got %0b expected 0", q[1].sat); end
    end
  endtask

  task automatic test_first_restart();
    q.delete();
    send_beat(1, 0, 4096, 0, 2048, 0);   // partial vector, dropped
    send_beat(1, 0, 2048, 0, 2048, 0);
    send_beat(0, 1, 2048, 0, 2048, 0);
    idle(12);
    n_cmp++; if (q.size() != 1) begin n_bad++; $display("FAIL restart_count: got %0d expected 1", q.size()); end
    if (q.size() >= 1) begin
      n_cmp++; if (q[0].ln != -2048) begin n_bad++; $display("FAIL restart_ln_p: got %0d expected -2048", q[0].ln); end
    end
  endtask

  task automatic test_reset_mid();
    q.delete();
    send_beat(1, 0, 2048, 0, 2048, 0);
    send_beat(0, 0, 2048, 0, 2048, 0);
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_ln_p !== 16'sd0) begin n_bad++; $display("FAIL rmid_ln_p: got %0d expected 0", out_ln_p); end
    n_cmp++; if (out_sat !== 1'b0) begin n_bad++; $display("FAIL rmid_sat: got %0b expected 0", out_sat); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %0b expected 1", in_ready); end
    idle(2);
    reset = 1'b0;
    send_beat(1, 1, 2048, 0, 2048, 0);
    idle(12);
    n_cmp++; if (q.size() != 1) begin n_bad++; $display("FAIL rmid_count: got %0d expected 1", q.size()); end
    if (q.size() >= 1) begin
      n_cmp++; if (q[0].ln != -1024) begin n_bad++; $display("FAIL rmid_ln_p_after: got %0d expected -1024", q[0].ln); end
    end
  endtask

  task automatic test_last_without_first();
    q.delete();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    send_beat(0, 1, 2048, 0, 2048, 0);   // accumulates onto acc=0
    idle(12);
    n_cmp++; if (q.size() != 1) begin n_bad++; $display("FAIL lastonly_count: got %0d expected 1", q.size()); end
    if (q.size() >= 1) begin
      n_cmp++; if (q[0].ln != -1024) begin n_bad++; $display("FAIL lastonly_ln_p: got %0d expected -1024", q[0].ln); end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    x = '0; mean = '0; omega = '0; k = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_bubbles();
    test_backpressure();
    test_saturation();
    test_first_restart();
    test_reset_mid();
    test_last_without_first();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gdp_stream.md
Name: gdp_stream

Overview:
- Parametrised, streaming successor of the diagonal-Gaussian log-probability pipeline.
- Accumulates ln p = k - 0.5 * sum_i omega_i * (x_i - mean_i)^2 over a vector delivered one dimension per beat.
- Adds a valid/ready handshake on both sides, bubble tolerance, back-pressure, configurable fixed-point format and saturating output with an overflow flag.
- Sits between the feature/model-parameter fetch logic and the class-score comparator.

Parameters:
- W, 16: sample/parameter/result width in bits, signed two's complement.
- F, 11: fractional bits, so 1.0 = 2^F.
- ACC_W, 40: accumulator width in bits; must be at least 2*W+2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a beat (one dimension) is present.
- in_ready  out  1  the block can accept a beat.
- in_first  in  1  this beat is the first dimension of a vector.
- in_last  in  1  this beat is the last dimension of a vector; k is sampled on this beat.
- x, mean, omega, k  in  W each  signed Q(W-F).F operands.
- out_valid  out  1  the result is valid and held until accepted.
- out_ready  in  1  the consumer accepts the result.
- out_ln_p  out  W  signed log-probability, Q(W-F).F.
- out_sat  out  1  the result was clamped, or the accumulator saturated during this vector.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, with ports named clk and reset.
- Reset values:
  - out_valid, out_ln_p, out_sat = 0.
  - All stage valids, the accumulator and the sticky overflow flag = 0.
  - in_ready = 1.
- Handshake:
  - A beat is accepted on a rising edge when in_valid && in_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stalled, every pipeline register, the accumulator and the outputs hold.
- Pipeline: each stage carries valid, first and last flags; k travels alongside the data. A bubble (in_valid=0) propagates as an invalid stage and must never modify the accumulator.
  - S1: d = x - mean, W+1 bits, exact.
  - S2: sq = (d*d) >>> F, 2W+2 bits, arithmetic (floor) shift.
  - S3: term = (sq * omega) >>> F, sign-extended to ACC_W.
  - S4: if first, acc = term; otherwise acc = acc + term.
    - The add saturates to the ACC_W signed range.
    - Saturation sets the sticky ovf flag.
    - A first beat clears ovf before applying its own saturation check.
  - S5, on a last beat only:
    - r = k - (acc >>> 1), computed at ACC_W+1 bits.
    - r is clamped to [-2^(W-1), 2^(W-1)-1].
    - out_ln_p <= clamped r.
    - out_sat <= clamped || ovf.
    - out_valid <= 1.
- Latency: the result is visible after the 5th rising edge, counting the edge that accepts the last beat as the 1st, with no stalls. Throughput is one beat per cycle.
- out_valid clears on an edge where out_ready=1, unless a new last beat completes S5 on the same edge; in that case out_valid stays 1 and the data updates.
- Boundary cases:
  - first && last on the same beat is a one-dimension vector.
  - A last beat arriving with no preceding first accumulates onto the current acc; after reset that value is 0.
  - first arriving mid-vector restarts accumulation and drops the partial vector silently.
  - Reset mid-vector or while stalled discards all in-flight data and the held result immediately.
- No division and no rounding other than the floor shifts above.

Decomposition:
- Package gdp_pkg holds:
  - default W/F constants;
  - the typedef num_t (logic signed [W-1:0] at the default width);
  - a function sat_trunc(value, width) used at S4 and S5.
- One natural sub-module: gdp_term. It implements S1-S3 (subtract, square, scale) as a stall-able three-stage pipeline with valid/first/last/k sideband.
- gdp_stream instantiates gdp_term and adds the accumulator, output stage and handshake.

Test Plan:
All values use W=16, F=11, ACC_W=40, so 1.0 = 2048.
- Single dimension:
  - Stimulus: x=2048, mean=0, omega=2048, k=0, first=last=1, out_ready=1.
  - Response: out_ln_p=-1024 (-0.5), out_sat=0, out_valid high for exactly 1 cycle on the 5th edge.
- Three dimensions, zero error, back-to-back:
  - Stimulus: x=mean=[100,-300,5000] with any omega, k=4096.
  - Response: out_ln_p=4096, out_sat=0.
  - Then an immediate second vector: x=[2048,0,4096], mean=[0,0,2048], omega=2048, k=0. This gives d=[2048,0,2048], acc=4096, so out_ln_p=-2048.
- Bubbles: repeat the second vector with in_valid low for 2 cycles between each beat -> identical result -2048, output delayed only by the bubbles.
- Back-pressure:
  - Stimulus: out_ready=0 for 4 cycles after out_valid rises, with the next vector presented.
  - Response: in_ready=0, out_ln_p stable, no beat lost. Once out_ready=1, both results appear in order with correct values.
- Saturation:
  - Stimulus: x=32767, mean=-32768, omega=32767, k=-32768, single dimension.
  - Response: out_ln_p=-32768, out_sat=1. The next normal vector gives out_sat=0.
- Reset mid-vector:
  - Stimulus: assert reset after 2 of 3 beats; release; send the single-dimension vector from the first test.
  - Response: outputs are 0 during reset, and the only result after release is -1024.
